// File: rtl/assoc_pkg.sv
// Shared constants and FSM encoding for the associative-memory datapath.
// The downstream comparator reuses SCORE_W and CLASS_W from here.
package assoc_pkg;
   localparam int NUM_CLASSES = 26;
   localparam int SCORE_W     = 13;
   localparam int CLASS_W     = 5;
   localparam int PC_W        = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/assoc_accumulator_popcount_tree.sv
// Combinational population count of one chunk; the parent registers the result.
module popcount_tree #(
   parameter int  CHUNK_W = 64,
   localparam int OUT_W   = $clog2(CHUNK_W) + 1
) (
   input  logic [CHUNK_W-1:0] bits,
   output logic [OUT_W-1:0]   count
);
   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK_W; i++) count = count + OUT_W'(bits[i]);
   end
endmodule

// File: rtl/assoc_accumulator.sv
// Streams query/class chunks through a 3-stage popcount pipeline and accumulates
// 26 similarity scores, presented together behind a valid/ready handshake.
module assoc_accumulator
   import assoc_pkg::*;
#(
   parameter int  D          = 4096,
   parameter int  CHUNK_W    = 64,
   parameter int  NUM_CHUNKS = D / CHUNK_W,
   parameter int  ADDR_W     = 11,
   localparam int QA_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   output logic                           busy,
   output logic                           cmem_en,
   output logic [ADDR_W-1:0]              cmem_addr,
   input  logic [CHUNK_W-1:0]             cmem_rdata,
   output logic                           qmem_en,
   output logic [QA_W-1:0]                qmem_addr,
   input  logic [CHUNK_W-1:0]             qmem_rdata,
   output logic [NUM_CLASSES*SCORE_W-1:0] scores,
   output logic                           scores_valid,
   input  logic                           scores_ready
);
   localparam int PCW = $clog2(CHUNK_W) + 1;

   if (D > 8191 || (D % CHUNK_W) != 0) begin : g_bad_d
      $error("assoc_accumulator: D must be <= 8191 and a multiple of CHUNK_W");
   end
   if ((2 ** ADDR_W) < NUM_CLASSES * NUM_CHUNKS) begin : g_bad_addr
      $error("assoc_accumulator: ADDR_W too small for NUM_CLASSES*NUM_CHUNKS");
   end

   state_t                                 state;
   logic [QA_W-1:0]                        chunk;
   logic [CLASS_W-1:0]                     cls;
   logic [2:0]                             vld_pipe;
   logic [2:1][CLASS_W-1:0]                tag_pipe;
   logic [PCW-1:0]                         pc, pc_q;
   logic [NUM_CLASSES-1:0][SCORE_W-1:0]    acc_all, scores_q;
   logic                                   last_issue, accept, issue_nxt;

   assign last_issue = (chunk == QA_W'(NUM_CHUNKS - 1)) && (cls == CLASS_W'(NUM_CLASSES - 1));
   assign accept     = (state == IDLE) && start;
   assign issue_nxt  = accept || ((state == RUN) && !last_issue);

   assign busy      = (state != IDLE);
   assign cmem_en   = vld_pipe[0];
   assign qmem_en   = vld_pipe[0];
   assign qmem_addr = chunk;
   assign scores    = scores_q;

   // Issue order is chunk-outer/class-inner, so the address steps by NUM_CHUNKS per class.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         chunk        <= '0;
         cls          <= '0;
         cmem_addr    <= '0;
         scores_valid <= 1'b0;
         scores_q     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= RUN;
               chunk     <= '0;
               cls       <= '0;
               cmem_addr <= '0;
            end
            RUN: if (last_issue) begin
               state <= FLUSH;
            end else if (cls == CLASS_W'(NUM_CLASSES - 1)) begin
               cls       <= '0;
               chunk     <= chunk + QA_W'(1);
               cmem_addr <= ADDR_W'(chunk) + ADDR_W'(1);
            end else begin
               cls       <= cls + CLASS_W'(1);
               cmem_addr <= cmem_addr + ADDR_W'(NUM_CHUNKS);
            end
            // Results are published only once the last accumulate has landed.
            FLUSH: if (vld_pipe[2:1] == 2'b00) begin
               state        <= DONE;
               scores_valid <= 1'b1;
               scores_q     <= acc_all;
            end
            DONE: if (scores_ready) begin
               state        <= IDLE;
               scores_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   popcount_tree #(.CHUNK_W(CHUNK_W)) u_pc (
      .bits  (qmem_rdata & cmem_rdata),
      .count (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
         pc_q     <= '0;
      end else begin
         vld_pipe    <= {vld_pipe[1:0], issue_nxt};
         tag_pipe[1] <= cls;
         tag_pipe[2] <= tag_pipe[1];
         if (vld_pipe[1]) pc_q <= pc;
      end
   end

   for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
      logic [SCORE_W-1:0] acc_r;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                                             acc_r <= '0;
         else if (accept)                                        acc_r <= '0;
         else if (vld_pipe[2] && tag_pipe[2] == CLASS_W'(g))     acc_r <= acc_r + SCORE_W'(pc_q);
      end
      assign acc_all[g] = acc_r;
   end
endmodule

// File: tb/tb_assoc_accumulator.sv
// Self-checking bench: memory models, a popcount reference model and a per-cycle monitor.
module tb_assoc_accumulator;
   import assoc_pkg::*;

   localparam int NC       = 64;
   localparam int NCLS     = 26;
   localparam int SW       = NCLS * 13;
   localparam int LAST_CYC = NCLS * NC + 3;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, scores_ready = 1'b0;
   logic          busy, cmem_en, qmem_en, scores_valid;
   logic [10:0]   cmem_addr;
   logic [5:0]    qmem_addr;
   logic [63:0]   cmem_rdata = '0, qmem_rdata = '0;
   logic [SW-1:0] scores;

   logic [63:0]   cls_mem [2048];
   logic [63:0]   q_mem [64];
   logic [SW-1:0] exp_vec;
   int            n_tests, n_fail, issue_idx;

   assoc_accumulator dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .cmem_en(cmem_en), .cmem_addr(cmem_addr), .cmem_rdata(cmem_rdata),
      .qmem_en(qmem_en), .qmem_addr(qmem_addr), .qmem_rdata(qmem_rdata),
      .scores(scores), .scores_valid(scores_valid), .scores_ready(scores_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cmem_en) cmem_rdata <= cls_mem[cmem_addr];
      if (qmem_en) qmem_rdata <= q_mem[qmem_addr];
   end

   task automatic check(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: score[c] = sum over chunks of popcount(query & class).
   task automatic compute_exp();
      for (int c = 0; c < NCLS; c++) begin
         int s = 0;
         for (int k = 0; k < NC; k++) s += $countones(q_mem[k] & cls_mem[c*NC + k]);
         exp_vec[c*13 +: 13] = 13'(s);
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < NCLS*NC; i++) cls_mem[i] = {$urandom(), $urandom()};
      for (int k = 0; k < NC; k++) q_mem[k] = {$urandom(), $urandom()};
   endtask

   // One cycle, then monitor the address stream and any presented result.
   task automatic tick();
      @(negedge clk);
      if (cmem_en || qmem_en) begin
         int ci = issue_idx % NCLS;
         int ch = issue_idx / NCLS;
         check("qmem_en", SW'(qmem_en), SW'(cmem_en));
         check("cmem_addr", SW'(cmem_addr), SW'(ci*NC + ch));
         check("qmem_addr", SW'(qmem_addr), SW'(ch));
         issue_idx++;
      end
      if (scores_valid) check("scores", scores, exp_vec);
   endtask

   task automatic check_reset_outs(input string nm);
      check({nm, "_busy"}, SW'(busy), '0);
      check({nm, "_valid"}, SW'(scores_valid), '0);
      check({nm, "_en"}, SW'({cmem_en, qmem_en}), '0);
      check({nm, "_addr"}, SW'({cmem_addr, qmem_addr}), '0);
      check({nm, "_scores"}, scores, '0);
   endtask

   task automatic run_inference(input string nm, input int pulse_at, input int hold, input logic start_with_ready);
      int k = 0;
      issue_idx = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, "_busy0"}, SW'(busy), SW'(1));
      while (!scores_valid && k < 3000) begin
         if (k == pulse_at) start = 1'b1;
         tick();
         start = 1'b0;
         k++;
      end
      check({nm, "_latency"}, SW'(k), SW'(LAST_CYC));
      check({nm, "_issues"}, SW'(issue_idx), SW'(NCLS*NC));
      for (int h = 0; h < hold; h++) begin
         if (h % 10 == 4) start = 1'b1;
         tick();
         start = 1'b0;
         check({nm, "_hold_valid"}, SW'({busy, scores_valid}), SW'(3));
      end
      scores_ready = 1'b1;
      start = start_with_ready;
      tick();
      scores_ready = 1'b0;
      start = 1'b0;
      check({nm, "_post_hs"}, SW'({busy, scores_valid}), '0);
      tick();
      check({nm, "_idle_busy"}, SW'(busy), '0);
      check({nm, "_idle_hold"}, scores, exp_vec);
   endtask

   initial begin
      logic [SW-1:0] lit;
      int            best;
      n_tests = 0;
      n_fail  = 0;
      issue_idx = 0;
      exp_vec = '0;
      for (int i = 0; i < 2048; i++) cls_mem[i] = '0;
      for (int k = 0; k < NC; k++) q_mem[k] = '0;

      repeat (3) tick();
      check_reset_outs("reset");
      rst_n = 1'b1;
      tick();

      // Zero query: every score is zero regardless of class contents.
      for (int i = 0; i < NCLS*NC; i++) cls_mem[i] = {$urandom(), $urandom()};
      for (int k = 0; k < NC; k++) q_mem[k] = '0;
      compute_exp();
      check("pin_zero_model", exp_vec, '0);
      run_inference("zeroq", -1, 0, 1'b0);
      check("zeroq_lit", scores, '0);

      // One matching class: score 4096 on class 5, argmax must be 5.
      for (int i = 0; i < NCLS*NC; i++) cls_mem[i] = (i / NC == 5) ? '1 : '0;
      for (int k = 0; k < NC; k++) q_mem[k] = '1;
      compute_exp();
      lit = '0;
      lit[5*13 +: 13] = 13'd4096;
      check("pin_one_model", exp_vec, lit);
      run_inference("oneclass", -1, 0, 1'b0);
      check("oneclass_lit", scores, lit);
      best = 0;
      for (int c = 1; c < NCLS; c++)
         if (scores[c*13 +: 13] > scores[best*13 +: 13]) best = c;
      check("argmax", SW'(best), SW'(5));

      // Ramp: class c has c+1 ones in chunk 0 and c ones in the last chunk.
      for (int i = 0; i < NCLS*NC; i++) cls_mem[i] = '0;
      for (int c = 0; c < NCLS; c++) begin
         logic [63:0] one = 64'd1;
         cls_mem[c*NC]        = (one << (c + 1)) - one;
         cls_mem[c*NC + NC-1] = (one << c) - one;
      end
      compute_exp();
      run_inference("ramp", -1, 0, 1'b1);
      for (int c = 0; c < NCLS; c++)
         check("ramp_lit", SW'(scores[c*13 +: 13]), SW'(2*c + 1));

      // Consumer back-pressure with start pulses while results are held.
      load_random();
      compute_exp();
      run_inference("hold", -1, 50, 1'b0);

      // Clean run vs run with a stray start mid-way on identical data.
      load_random();
      compute_exp();
      run_inference("clean", -1, 0, 1'b0);
      run_inference("midstart", 300, 0, 1'b0);

      // Abort via reset at cycle 800, then a fresh run on new data.
      load_random();
      compute_exp();
      issue_idx = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 800; k++) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outs("abort");
      for (int r = 0; r < 3; r++) begin
         tick();
         check_reset_outs("abort_hold");
      end
      rst_n = 1'b1;
      tick();
      check("abort_idle", SW'({busy, scores_valid}), '0);
      load_random();
      compute_exp();
      run_inference("after_abort", -1, 5, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
